hdr_exit_restart_detector: RTL and testbench

//  Watches the raw I3C SCL/SDA lines while the target is in HDR-DDR and detects the
//  HDR Restart and HDR Exit patterns. Feeds Target_engine directly: o_rstdet_RESTART
//  -> i_rstdet_RESTART, o_exitdet_EXIT -> i_exitdet_EXIT. Pure pattern detection;

---
 rtl/hdr_exit_restart_detector_pkg.sv | 17 +
 rtl/hdr_exit_restart_detector_sync_edge_det.sv | 70 +++++++
 rtl/hdr_exit_restart_detector.sv | 138 +++++++++++++
 tb/tb_hdr_exit_restart_detector.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_exit_restart_detector_pkg.sv
// Shared types and constants for the HDR Exit / HDR Restart detector.
//   hdr_det_state_e : detector FSM states (also exported on the debug port)
//   RESTART_FALLS   : SDA falls in one SCL-low window that form an HDR Restart
//   EXIT_FALLS      : SDA falls in one SCL-low window that form an HDR Exit
package hdr_exit_restart_detector_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    WAIT_STOP = 2'd2
  } hdr_det_state_e;

  localparam int                CNT_W         = 3;
  localparam logic [CNT_W-1:0]  RESTART_FALLS = 3'd2;
  localparam logic [CNT_W-1:0]  EXIT_FALLS    = 3'd4;

endpackage

// File: rtl/hdr_exit_restart_detector_sync_edge_det.sv
// hdr_sync_edge_det: brings one asynchronous bus line into the i_sys_clk domain,
// optionally glitch-filters it, and produces single-cycle edge flags.
// Optional feature macro: HDR_DET_GLITCH_FILTER_EN (adds FILT_CYCLES stability filter).
// Ports:
//   i_sys_clk  in  system clock
//   i_sys_rst  in  asynchronous active-low reset (flops preset to 1 = idle bus)
//   line       in  raw pad signal
//   level      out synchronized (and filtered) line level
//   rise       out one-cycle flag, level went 0 -> 1
//   fall       out one-cycle flag, level went 1 -> 0
module hdr_sync_edge_det #(
  parameter int SYNC_STAGES = 2
`ifdef HDR_DET_GLITCH_FILTER_EN
  , parameter int FILT_CYCLES = 3
`endif
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) sync_q <= '1;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef HDR_DET_GLITCH_FILTER_EN
  // The filtered level only follows sync_out once sync_out has disagreed with it
  // for FILT_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [FW-1:0] stab_q;
  logic          filt_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      stab_q <= '0;
      filt_q <= 1'b1;
    end else if (sync_out == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == FW'(FILT_CYCLES - 1)) begin
      filt_q <= sync_out;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_out;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) prev_q <= 1'b1;
    else            prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/hdr_exit_restart_detector.sv
// hdr_exit_restart_detector: watches raw SCL/SDA during HDR-DDR and flags the
// HDR Restart (2 SDA falls in an SCL-low window, SDA high at SCL rise) and the
// HDR Exit (4 SDA falls in an SCL-low window). Never drives the bus.
// Optional feature macro: HDR_DET_GLITCH_FILTER_EN (line glitch filter, FILT_CYCLES).
// Ports:
//   i_sys_clk          in  system clock
//   i_sys_rst          in  asynchronous active-low reset
//   i_hdr_en           in  engine in HDR; low forces IDLE and clears the count
//   i_scl, i_sda       in  raw pad lines (asynchronous)
//   o_rstdet_RESTART   out one-cycle HDR Restart pulse
//   o_exitdet_EXIT     out one-cycle HDR Exit pulse
//   o_pattern_cnt      out SDA falls counted in the current SCL-low window (saturates at 4)
//   o_busy             out high in COUNT or WAIT_STOP
//   o_dbg_state        out current FSM state
module hdr_exit_restart_detector
  import hdr_exit_restart_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef HDR_DET_GLITCH_FILTER_EN
  , parameter int FILT_CYCLES = 3
`endif
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_hdr_en,
  input  logic                 i_scl,
  input  logic                 i_sda,
  output logic                 o_rstdet_RESTART,
  output logic                 o_exitdet_EXIT,
  output logic [CNT_W-1:0]     o_pattern_cnt,
  output logic                 o_busy,
  output hdr_det_state_e       o_dbg_state
);

  logic scl_s, scl_rise, scl_fall_unused;
  logic sda_s, sda_rise, sda_fall;

`ifdef HDR_DET_GLITCH_FILTER_EN
  hdr_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl (
`else
  hdr_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
`endif
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .line      (i_scl),
    .level     (scl_s),
    .rise      (scl_rise),
    .fall      (scl_fall_unused)
  );

`ifdef HDR_DET_GLITCH_FILTER_EN
  hdr_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda (
`else
  hdr_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
`endif
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .line      (i_sda),
    .level     (sda_s),
    .rise      (sda_rise),
    .fall      (sda_fall)
  );

  hdr_det_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart_q, restart_d;
  logic             exit_q, exit_d;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      restart_q <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      exit_q    <= exit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    exit_d    = 1'b0;
    if (!i_hdr_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!scl_s) begin
            state_d = COUNT;
            cnt_d   = '0;
          end
        end
        COUNT: begin
          if (scl_rise && sda_fall) begin
            // SDA moving exactly as SCL rises is a protocol violation: drop it.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (scl_rise) begin
            // End of the SCL-low window; only a 2-fall window with SDA high is a Restart.
            restart_d = (cnt_q == RESTART_FALLS) && sda_s;
            state_d   = IDLE;
            cnt_d     = '0;
          end else if (sda_fall) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == EXIT_FALLS - 1'b1) begin
              exit_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          // Count holds at EXIT_FALLS until the STOP that ends HDR.
          if (sda_rise && scl_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_rstdet_RESTART = restart_q;
  assign o_exitdet_EXIT   = exit_q;
  assign o_pattern_cnt    = cnt_q;
  assign o_busy           = (state_q != IDLE);
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_hdr_exit_restart_detector.sv
// Bench for hdr_exit_restart_detector: directed scenarios with literal expectations
// plus randomized SCL-low windows, all checked every cycle against a pad-level model.
module tb_hdr_exit_restart_detector;
  import hdr_exit_restart_detector_pkg::*;

  localparam int S = 2;
`ifdef HDR_DET_GLITCH_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 0;
`endif
  // pad change -> registered pulse, in clocks
  localparam int LAT = S + 1 + F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hdr_en = 1'b0;
  logic scl = 1'b1;
  logic sda = 1'b1;
  always #10 clk = ~clk;

  logic           o_rstdet_RESTART, o_exitdet_EXIT, o_busy;
  logic [2:0]     o_pattern_cnt;
  hdr_det_state_e o_dbg_state;

  hdr_exit_restart_detector dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst_n),
    .i_hdr_en         (hdr_en),
    .i_scl            (scl),
    .i_sda            (sda),
    .o_rstdet_RESTART (o_rstdet_RESTART),
    .o_exitdet_EXIT   (o_exitdet_EXIT),
    .o_pattern_cnt    (o_pattern_cnt),
    .o_busy           (o_busy),
    .o_dbg_state      (o_dbg_state)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pad samples are kept newest-first; the detector "sees" a line S-1 samples late,
  // and with the filter it only adopts a value the sync stage held for F samples.
  logic h_scl[$];
  logic h_sda[$];
  logic m_scl_l, m_scl_p, m_sda_l, m_sda_p;
  bit   m_win, m_done, m_r, m_e;
  int   m_cnt;

  function automatic logic seen(input logic h[$], input logic held);
    if (F == 0) return h[S-1];
    for (int i = S; i < S + F; i++)
      if (h[i] != h[S]) return held;
    return h[S];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_scl.delete();
      h_sda.delete();
      for (int i = 0; i < S + F + 1; i++) begin
        h_scl.push_back(1'b1);
        h_sda.push_back(1'b1);
      end
      m_scl_l = 1'b1; m_scl_p = 1'b1; m_sda_l = 1'b1; m_sda_p = 1'b1;
      m_win = 0; m_done = 0; m_cnt = 0; m_r = 0; m_e = 0;
    end else begin
      bit s_rise, d_fall, d_rise;
      s_rise = m_scl_l & ~m_scl_p;
      d_fall = ~m_sda_l & m_sda_p;
      d_rise = m_sda_l & ~m_sda_p;
      m_r = 0;
      m_e = 0;
      if (!hdr_en) begin
        m_win = 0; m_done = 0; m_cnt = 0;
      end else if (m_done) begin
        if (d_rise && m_scl_l) begin m_done = 0; m_cnt = 0; end
      end else if (m_win) begin
        if (s_rise) begin
          m_r   = !d_fall && m_cnt == 2 && m_sda_l;
          m_win = 0;
          m_cnt = 0;
        end else if (d_fall) begin
          m_cnt++;
          if (m_cnt == 4) begin m_e = 1; m_win = 0; m_done = 1; end
        end
      end else if (!m_scl_l) begin
        m_win = 1; m_cnt = 0;
      end
      h_scl.push_front(scl); void'(h_scl.pop_back());
      h_sda.push_front(sda); void'(h_sda.pop_back());
      m_scl_p = m_scl_l; m_scl_l = seen(h_scl, m_scl_l);
      m_sda_p = m_sda_l; m_sda_l = seen(h_sda, m_sda_l);
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] act, exp;
      hdr_det_state_e exp_st;
      exp_st = m_done ? WAIT_STOP : (m_win ? COUNT : IDLE);
      act = {o_rstdet_RESTART, o_exitdet_EXIT, o_pattern_cnt, o_busy, o_dbg_state};
      exp = {m_r, m_e, 3'(m_cnt), (m_win | m_done), exp_st};
      tests++;
      if (act !== exp) begin
        fails++;
        if (fails < 20)
          $display("FAIL model_cmp: got r=%0b e=%0b cnt=%0d busy=%0b st=%0d expected r=%0b e=%0b cnt=%0d busy=%0b st=%0d (t=%0t)",
                   act[7], act[6], act[5:3], act[2], act[1:0], exp[7], exp[6], exp[5:3], exp[2], exp[1:0], $time);
      end
    end
  end

  // pulse counters (pre-edge values sampled on rising edges)
  int n_rst = 0;
  int n_exit = 0;
  always @(posedge clk) begin
    if (o_rstdet_RESTART) n_rst++;
    if (o_exitdet_EXIT)   n_exit++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap();
    wait_clk($urandom_range(10, 14));
  endtask

  task automatic set_scl(input logic v);
    scl = v;
    gap();
  endtask

  task automatic set_sda(input logic v);
    sda = v;
    gap();
  endtask

  task automatic sda_fall_pulse();
    set_sda(1'b0);
    set_sda(1'b1);
  endtask

  task automatic sda_glitch();
    sda = 1'b0;
    wait_clk(1);
    sda = 1'b1;
    gap();
  endtask

  task automatic record(input int n, output int rvec, output int evec);
    rvec = 0;
    evec = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (o_rstdet_RESTART) rvec |= (1 << (i - 1));
      if (o_exitdet_EXIT)   evec |= (1 << (i - 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv, ev, base_r, base_e, k;

    // reset
    wait_clk(3);
    check("rst_restart", o_rstdet_RESTART, 0);
    check("rst_exit", o_exitdet_EXIT, 0);
    check("rst_cnt", o_pattern_cnt, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    wait_clk(3);
    check("post_rst_cnt", o_pattern_cnt, 0);
    check("post_rst_busy", o_busy, 0);

    // HDR Restart
    hdr_en = 1'b1;
    gap();
    set_scl(1'b0);
    sda_fall_pulse();
    sda_fall_pulse();
    check("restart_cnt2", o_pattern_cnt, 2);
    check("restart_busy", o_busy, 1);
    base_e = n_exit;
    scl = 1'b1;
    record(LAT + 4, rv, ev);
    check("restart_pulse_vec", rv, 1 << (LAT - 1));
    check("restart_no_exit", ev, 0);
    gap();
    check("restart_idle", o_busy, 0);

    // HDR Exit then STOP
    set_scl(1'b0);
    sda_fall_pulse();
    sda_fall_pulse();
    sda_fall_pulse();
    sda = 1'b0;
    record(LAT + 4, rv, ev);
    check("exit_pulse_vec", ev, 1 << (LAT - 1));
    check("exit_no_restart", rv, 0);
    gap();
    check("exit_cnt4", o_pattern_cnt, 4);
    check("exit_busy", o_busy, 1);
    check("exit_state", o_dbg_state, WAIT_STOP);
    set_sda(1'b1);
    sda_fall_pulse();
    check("exit_hold_cnt", o_pattern_cnt, 4);
    set_scl(1'b1);
    set_sda(1'b0);
    set_sda(1'b1);
    check("stop_busy", o_busy, 0);
    check("stop_cnt", o_pattern_cnt, 0);

    // DDR data bits: 0/1/3 falls per low phase
    base_r = n_rst;
    base_e = n_exit;
    for (int b = 0; b < 32; b++) begin
      set_scl(1'b0);
      case ($urandom_range(0, 2))
        0: k = 0;
        1: k = 1;
        default: k = 3;
      endcase
      for (int j = 0; j < k; j++) sda_fall_pulse();
      set_scl(1'b1);
    end
    check("ddr_no_restart", n_rst - base_r, 0);
    check("ddr_no_exit", n_exit - base_e, 0);

    // hdr_en gating of a partial Restart
    base_r = n_rst;
    set_scl(1'b0);
    sda_fall_pulse();
    sda_fall_pulse();
    hdr_en = 1'b0;
    wait_clk(1);
    check("gate_cnt", o_pattern_cnt, 0);
    check("gate_busy", o_busy, 0);
    set_scl(1'b1);
    check("gate_no_restart", n_rst - base_r, 0);
    hdr_en = 1'b1;
    gap();

    // simultaneous SCL rise and SDA fall after 3 falls
    base_e = n_exit;
    set_scl(1'b0);
    sda_fall_pulse();
    sda_fall_pulse();
    sda_fall_pulse();
    sda = 1'b0;
    scl = 1'b1;
    gap();
    check("viol_busy", o_busy, 0);
    set_sda(1'b1);
    check("viol_no_exit", n_exit - base_e, 0);

    // async reset in the middle of a pattern
    set_scl(1'b0);
    sda_fall_pulse();
    sda_fall_pulse();
    #3 rst_n = 1'b0;
    #1;
    check("arst_cnt", o_pattern_cnt, 0);
    check("arst_busy", o_busy, 0);
    wait_clk(2);
    rst_n = 1'b1;
    set_scl(1'b1);
    check("arst_idle", o_busy, 0);

`ifdef HDR_DET_GLITCH_FILTER_EN
    // short SDA glitches vanish; a real Exit arrives LAT clocks after the 4th fall
    set_scl(1'b0);
    sda_glitch();
    sda_glitch();
    sda_glitch();
    check("glitch_cnt0", o_pattern_cnt, 0);
    sda_fall_pulse();
    sda_fall_pulse();
    sda_fall_pulse();
    sda = 1'b0;
    record(LAT + 4, rv, ev);
    check("glitch_exit_vec", ev, 1 << (LAT - 1));
    gap();
    set_scl(1'b1);
    set_sda(1'b1);
    check("glitch_stop", o_busy, 0);
`endif

    // randomized SCL-low windows
    for (int w = 0; w < 40; w++) begin
      set_scl(1'b0);
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 5) == 0) sda_glitch();
        else                           sda_fall_pulse();
      end
      if ($urandom_range(0, 7) == 0) begin
        hdr_en = 1'b0;
        gap();
        hdr_en = 1'b1;
      end
      case ($urandom_range(0, 3))
        0: begin sda = 1'b0; scl = 1'b1; gap(); end
        1: begin set_sda(1'b0); set_scl(1'b1); end
        default: set_scl(1'b1);
      endcase
      set_sda(1'b0);
      set_sda(1'b1);
    end

    wait_clk(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
